// File: rtl/rgb2ycbcr_pipe.sv
// -----------------------------------------------------------------------------
// rgb2ycbcr_pipe
//
// Fully pipelined BT.601 full-range RGB -> YCbCr converter for the camera
// video path. One pixel per clock, no backpressure. Video timing (DE, HSYNC,
// VSYNC) is carried through a shift register of exactly LATENCY stages so it
// stays aligned with the converted data.
//
// Parameters
//   IN_FMT   : 0 = RGB565 in in_data[15:0], 1 = RGB888 {R,G,B} in in_data[23:0]
//   OUT_MODE : 0 = gray {16'h0,Y}, 1 = YCbCr444 {Y,Cb,Cr},
//              2 = YCbCr422 {8'h0,C,Y} with pair-averaged chroma
//   LATENCY  : derived, 3 for modes 0/1 and 5 for mode 2
//
// Ports
//   clk                          pixel clock
//   rst                          synchronous active-high reset
//   in_de, in_hsync, in_vsync    input video timing
//   in_data[23:0]                input pixel
//   out_de, out_hsync, out_vsync timing delayed by LATENCY cycles
//   out_data[23:0]               converted pixel, layout set by OUT_MODE
//
// Optional feature (macro YCBCR_ROUND_EN)
//   Defined  : +128 before the >>8 (round half up) and (a+b+1)>>1 for the
//              4:2:2 chroma average.
//   Undefined: pure truncation on both. Latency is the same either way.
// -----------------------------------------------------------------------------
module rgb2ycbcr_pipe #(
  parameter int unsigned IN_FMT   = 0,
  parameter int unsigned OUT_MODE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_de,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic [23:0] in_data,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic [23:0] out_data
);

  localparam int unsigned LATENCY = (OUT_MODE == 2) ? 5 : 3;

`ifdef YCBCR_ROUND_EN
  localparam logic signed [17:0] SUM_RND = 18'sd128;
  localparam logic        [8:0]  AVG_RND = 9'd1;
`else
  localparam logic signed [17:0] SUM_RND = 18'sd0;
  localparam logic        [8:0]  AVG_RND = 9'd0;
`endif

  // Chroma offset of 128 expressed before the >>8 scaling.
  localparam logic signed [17:0] C_OFFSET = 18'sd32768;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic signed [17:0] sx(input logic [15:0] v);
    return signed'({2'b00, v});
  endfunction

  // Arithmetic shift by 8, then saturate to the 8-bit range.
  function automatic logic [7:0] clamp8(input logic signed [17:0] v);
    logic signed [17:0] s;
    s = v >>> 8;
    if (s < 18'sd0)
      return 8'h00;
    else if (s > 18'sd255)
      return 8'hFF;
    else
      return s[7:0];
  endfunction

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + AVG_RND;
    return s[8:1];
  endfunction

  // ---------------------------------------------------------------------------
  // Input expansion to 8 bits per channel
  // ---------------------------------------------------------------------------
  logic [7:0] w_r8;
  logic [7:0] w_g8;
  logic [7:0] w_b8;

  generate
    if (IN_FMT == 0) begin : g_rgb565
      // MSB replication keeps full-scale 5/6-bit codes at exactly 255.
      assign w_r8 = {in_data[15:11], in_data[15:13]};
      assign w_g8 = {in_data[10:5],  in_data[10:9]};
      assign w_b8 = {in_data[4:0],   in_data[4:2]};
      logic w_unused_hi;
      assign w_unused_hi = ^in_data[23:16];
    end else begin : g_rgb888
      assign w_r8 = in_data[23:16];
      assign w_g8 = in_data[15:8];
      assign w_b8 = in_data[7:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // S1: nine coefficient products
  // ---------------------------------------------------------------------------
  logic [15:0] r_py_r, r_py_g, r_py_b;
  logic [15:0] r_pcb_r, r_pcb_g, r_pcb_b;
  logic [15:0] r_pcr_r, r_pcr_g, r_pcr_b;

  // NOTE: all pipeline state uses non-blocking assignments so every stage
  // samples the previous stage's value from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_py_r  <= '0;
      r_py_g  <= '0;
      r_py_b  <= '0;
      r_pcb_r <= '0;
      r_pcb_g <= '0;
      r_pcb_b <= '0;
      r_pcr_r <= '0;
      r_pcr_g <= '0;
      r_pcr_b <= '0;
    end else begin
      r_py_r  <= 16'(w_r8) * 16'd77;
      r_py_g  <= 16'(w_g8) * 16'd150;
      r_py_b  <= 16'(w_b8) * 16'd29;
      r_pcb_r <= 16'(w_r8) * 16'd43;
      r_pcb_g <= 16'(w_g8) * 16'd85;
      r_pcb_b <= 16'(w_b8) * 16'd128;
      r_pcr_r <= 16'(w_r8) * 16'd128;
      r_pcr_g <= 16'(w_g8) * 16'd107;
      r_pcr_b <= 16'(w_b8) * 16'd21;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: signed sums with chroma offset and optional rounding
  // ---------------------------------------------------------------------------
  logic signed [17:0] r_y2, r_cb2, r_cr2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y2  <= '0;
      r_cb2 <= '0;
      r_cr2 <= '0;
    end else begin
      r_y2  <= sx(r_py_r) + sx(r_py_g) + sx(r_py_b) + SUM_RND;
      r_cb2 <= sx(r_pcb_b) - sx(r_pcb_r) - sx(r_pcb_g) + C_OFFSET + SUM_RND;
      r_cr2 <= sx(r_pcr_r) - sx(r_pcr_g) - sx(r_pcr_b) + C_OFFSET + SUM_RND;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: scale and clamp to 8 bits
  // ---------------------------------------------------------------------------
  logic [7:0] r_s3_y, r_s3_cb, r_s3_cr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_y  <= '0;
      r_s3_cb <= '0;
      r_s3_cr <= '0;
    end else begin
      r_s3_y  <= clamp8(r_y2);
      r_s3_cb <= clamp8(r_cb2);
      r_s3_cr <= clamp8(r_cr2);
    end
  end

  // ---------------------------------------------------------------------------
  // Timing delay line: r_sync[k] is aligned with pipeline stage k+1.
  // Each entry is {de, hsync, vsync}.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0][2:0] r_sync;

  // NOTE: the delay line is cleared on reset, not just the data stages, so a
  // mid-line reset cannot leave stale DE bits that would qualify garbage data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[LATENCY-2:0], {in_de, in_hsync, in_vsync}};
    end
  end

  assign out_de    = r_sync[LATENCY-1][2];
  assign out_hsync = r_sync[LATENCY-1][1];
  assign out_vsync = r_sync[LATENCY-1][0];

  // ---------------------------------------------------------------------------
  // Output formatting
  // ---------------------------------------------------------------------------
  generate
    if (OUT_MODE == 2) begin : g_ycbcr422
      logic       w_de3;
      logic       w_de4;
      logic [7:0] r_y4, r_cb4, r_cr4;
      logic [7:0] r_crsave;
      logic       r_phase;
      logic [7:0] r_c5, r_y5;

      assign w_de3 = r_sync[2][2];
      assign w_de4 = r_sync[3][2];

      // r_phase is the parity of the pixel currently in S4; it restarts at
      // even whenever S4 sees a blanking cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_y4     <= '0;
          r_cb4    <= '0;
          r_cr4    <= '0;
          r_crsave <= '0;
          r_phase  <= 1'b0;
          r_c5     <= '0;
          r_y5     <= '0;
        end else begin
          r_y4    <= r_s3_y;
          r_cb4   <= r_s3_cb;
          r_cr4   <= r_s3_cr;
          r_phase <= w_de4 ? ~r_phase : 1'b0;

          if (!w_de4) begin
            r_c5 <= '0;
            r_y5 <= '0;
          end else if (r_phase) begin
            // Odd pixel: Cr averaged when its even partner went out.
            r_c5 <= r_crsave;
            r_y5 <= r_y4;
          end else begin
            r_y5 <= r_y4;
            if (w_de3) begin
              // Partner is one stage behind in S3; average both chroma now.
              r_c5     <= avg8(r_cb4, r_s3_cb);
              r_crsave <= avg8(r_cr4, r_s3_cr);
            end else begin
              // Odd-length run tail: no partner, pass Cb through.
              r_c5 <= r_cb4;
            end
          end
        end
      end

      assign out_data = {8'h00, r_c5, r_y5};
    end else if (OUT_MODE == 0) begin : g_gray
      logic w_unused_chroma;
      assign w_unused_chroma = ^{r_s3_cb, r_s3_cr};
      assign out_data = {16'h0000, r_s3_y};
    end else begin : g_ycbcr444
      assign out_data = {r_s3_y, r_s3_cb, r_s3_cr};
    end
  endgenerate

endmodule
